// File: rtl/rs_arb_pkg.sv
// Shared definitions for the round-robin RS lock arbiter:
// FSM state encoding and default configuration constants.
package rs_arb_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_HOLD_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ... (mod N_REQ)
// and returns the first requesting index, its one-hot form and a valid flag.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int CW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [CW-1:0]    i_last,
    output logic             o_valid,
    output logic [N_REQ-1:0] o_onehot,
    output logic [CW-1:0]    o_idx
);

    int w_j;

    // Walk the requesters starting just after the last owner; first hit wins.
    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_j      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_j = (int'(i_last) + i) % N_REQ;
            if (!o_valid && i_req[w_j]) begin
                o_valid     = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx       = CW'(w_j);
            end
        end
    end

endmodule

// File: rtl/rs_lock_arbiter.sv
// Round-robin lock controller driving a shared RS resource flop.
// Grants one requester at a time, pulses set_o on grant and reset_o on
// release, with a two-cycle gap (DRAIN + IDLE) between consecutive grants.
// Optional forced release after HOLD_MAX cycles: define RS_ARB_TIMEOUT_EN.
//
// Handshake: req is a level held while a requester wants the lock; gnt is the
// registered one-hot answer. The owner gives the lock back with a one-cycle
// rel pulse on its own bit; any other rel bit is flagged on err_o and ignored.
module rs_lock_arbiter
    import rs_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           rel,
    output logic [N_REQ-1:0]           gnt,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       set_o,
    output logic                       reset_o,
    output logic                       err_o,
    output logic                       timeout_o,
    output logic [1:0]                 dbg_state
);

    localparam int CW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || HOLD_MAX < 1) begin : g_param_check
        $error("rs_lock_arbiter: N_REQ must be 2..16 and HOLD_MAX >= 1");
    end

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [CW-1:0]      r_owner;
    logic               r_busy;
    logic               r_set;
    logic               r_reset;
    logic               r_err;
    logic               r_timeout;

    logic               w_pick_valid;
    logic [N_REQ-1:0]   w_pick_onehot;
    logic [CW-1:0]      w_pick_idx;
    logic               w_owned;
    logic               w_own_rel;
    logic               w_bad_rel;
    logic               w_timeout;
    logic               w_release;

    rr_pick #(
        .N_REQ (N_REQ),
        .CW    (CW)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_owner),
        .o_valid  (w_pick_valid),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

    // While owned, r_gnt is exactly the owner's one-hot, so it masks rel.
    assign w_owned   = (r_state == GRANT) || (r_state == HOLD);
    assign w_own_rel = w_owned && |(rel & r_gnt);
    assign w_bad_rel = w_owned ? |(rel & ~r_gnt) : |rel;
    assign w_release = w_own_rel || w_timeout;

`ifdef RS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(HOLD_MAX + 1);
    logic [TW-1:0] r_cnt;

    // Hold counter: cleared when a grant is issued, counts every owned cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (w_owned && (r_cnt != TW'(HOLD_MAX))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The edge on which the count reaches HOLD_MAX forces the release.
    assign w_timeout = w_owned && (r_cnt == TW'(HOLD_MAX - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Lock FSM: all outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_owner   <= CW'(N_REQ - 1);
            r_busy    <= 1'b0;
            r_set     <= 1'b0;
            r_reset   <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_err     <= w_bad_rel;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_set   <= 1'b0;
                    r_reset <= 1'b0;
                    if (w_pick_valid) begin
                        r_state <= GRANT;
                        r_gnt   <= w_pick_onehot;
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_set   <= 1'b1;
                    end
                end
                GRANT, HOLD: begin
                    r_set <= 1'b0;
                    if (w_release) begin
                        r_state   <= DRAIN;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_reset   <= 1'b1;
                        r_timeout <= w_timeout && !w_own_rel;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                DRAIN: begin
                    r_reset <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign set_o     = r_set;
    assign reset_o   = r_reset;
    assign err_o     = r_err;
    assign timeout_o = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rs_lock_arbiter.sv
// Directed bench for rs_lock_arbiter (N_REQ=4, HOLD_MAX=16).
module tb_rs_lock_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       set_o;
    logic       reset_o;
    logic       err_o;
    logic       timeout_o;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    rs_lock_arbiter #(
        .N_REQ    (4),
        .HOLD_MAX (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .busy      (busy),
        .owner     (owner),
        .set_o     (set_o),
        .reset_o   (reset_o),
        .err_o     (err_o),
        .timeout_o (timeout_o),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_gnt;

    initial begin
        rst = 1'b0;
        req = 4'b1111;
        rel = 4'b0000;
        #23;
        // reset state, requests pending
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_set",   32'(set_o), 32'h0);
        chk("rst_reset", 32'(reset_o), 32'h0);
        chk("rst_err",   32'(err_o), 32'h0);
        chk("rst_to",    32'(timeout_o), 32'h0);
        chk("rst_owner", 32'(owner), 32'h3);

        // release reset: first grant goes to requester 0
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("g0_gnt",   32'(gnt), 32'h1);
        chk("g0_set",   32'(set_o), 32'h1);
        chk("g0_busy",  32'(busy), 32'h1);
        chk("g0_owner", 32'(owner), 32'h0);

        // fairness: each owner releases two cycles after its grant
        for (int k = 0; k < 4; k++) begin
            exp_gnt = 4'b0001 << k;
            step();
            chk("rr_hold_gnt", 32'(gnt), 32'(exp_gnt));
            chk("rr_hold_set", 32'(set_o), 32'h0);
            rel = exp_gnt;
            step();
            rel = 4'b0000;
            chk("rr_rel_gnt",   32'(gnt), 32'h0);
            chk("rr_rel_reset", 32'(reset_o), 32'h1);
            chk("rr_rel_busy",  32'(busy), 32'h0);
            chk("rr_rel_set",   32'(set_o), 32'h0);
            step();
            chk("rr_gap_gnt",   32'(gnt), 32'h0);
            chk("rr_gap_reset", 32'(reset_o), 32'h0);
            step();
            exp_gnt = 4'b0001 << ((k + 1) % 4);
            chk("rr_next_gnt",   32'(gnt), 32'(exp_gnt));
            chk("rr_next_set",   32'(set_o), 32'h1);
            chk("rr_next_owner", 32'(owner), 32'((k + 1) % 4));
        end

        // owner 0 gives up, owner 1 gets the lock
        step();
        rel = 4'b0001;
        step();
        rel = 4'b0000;
        step();
        step();
        chk("own1_gnt", 32'(gnt), 32'h2);
        step();
        // illegal release from requester 2 while 1 owns
        rel = 4'b0100;
        step();
        rel = 4'b0000;
        chk("ill_err",  32'(err_o), 32'h1);
        chk("ill_gnt",  32'(gnt), 32'h2);
        chk("ill_busy", 32'(busy), 32'h1);
        step();
        chk("ill_err_clr", 32'(err_o), 32'h0);
        chk("ill_gnt2",    32'(gnt), 32'h2);

        // release 1 -> owner 2
        rel = 4'b0010;
        step();
        rel = 4'b0000;
        step();
        step();
        chk("own2_gnt", 32'(gnt), 32'h4);
        step();
        // simultaneous rel[2] and req[2]: release wins, 0 is next after 2
        req = 4'b0101;
        rel = 4'b0100;
        step();
        rel = 4'b0000;
        chk("sim_gnt",   32'(gnt), 32'h0);
        chk("sim_reset", 32'(reset_o), 32'h1);
        chk("sim_err",   32'(err_o), 32'h0);
        step();
        step();
        chk("sim_next_gnt",   32'(gnt), 32'h1);
        chk("sim_next_owner", 32'(owner), 32'h0);

        // multi-bit rel including owner's: release plus err
        step();
        rel = 4'b0011;
        step();
        chk("multi_gnt",   32'(gnt), 32'h0);
        chk("multi_reset", 32'(reset_o), 32'h1);
        chk("multi_err",   32'(err_o), 32'h1);
        // rel during DRAIN: ignored, flagged
        rel = 4'b0001;
        step();
        rel = 4'b0000;
        chk("drain_err",   32'(err_o), 32'h1);
        chk("drain_reset", 32'(reset_o), 32'h0);
        step();
        chk("after_drain_gnt", 32'(gnt), 32'h4);
        chk("after_drain_err", 32'(err_o), 32'h0);

        // owner drops req without rel: lock is kept
        req = 4'b0000;
`ifdef RS_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("to_pre_gnt", 32'(gnt), 32'h4);
        chk("to_pre_to",  32'(timeout_o), 32'h0);
        step();
        chk("to_gnt",   32'(gnt), 32'h0);
        chk("to_to",    32'(timeout_o), 32'h1);
        chk("to_reset", 32'(reset_o), 32'h1);
        step();
        chk("to_to_clr", 32'(timeout_o), 32'h0);
        req = 4'b0100;
        step();
        step();
        chk("to_regrant", 32'(gnt), 32'h4);
        step();
`else
        for (int i = 0; i < 100; i++) step();
        chk("hold_gnt",  32'(gnt), 32'h4);
        chk("hold_busy", 32'(busy), 32'h1);
        chk("hold_to",   32'(timeout_o), 32'h0);
`endif

        // asynchronous reset mid-hold
        #2;
        rst = 1'b0;
        #1;
        chk("ar_gnt",   32'(gnt), 32'h0);
        chk("ar_busy",  32'(busy), 32'h0);
        chk("ar_reset", 32'(reset_o), 32'h0);
        chk("ar_owner", 32'(owner), 32'h3);
        step();
        chk("ar_reset2", 32'(reset_o), 32'h0);
        chk("ar_gnt2",   32'(gnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
